// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encoding, ALU command width and PC source codes shared by the MIPS control blocks.
package mips_ctrl_pkg;
  localparam int EXEC_CMD_W = 3;
  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BRANCH = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd7
  } state_t;
  typedef struct packed {
    logic [EXEC_CMD_W-1:0] cmd;
    logic mem_read;
    logic mem_write;
    logic wb_enable;
    logic is_immediate;
    logic branch_type;
  } dec_fields_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles of a memory handshake and flags the timeout cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (count_en) count <= count + 1'b1;
  end
  // expired marks the cycle that would be the MEM_TIMEOUT-th consecutive wait
  assign expired = count_en && (count == CW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps each instruction through fetch/decode/execute/memory/writeback and
// turns the latched decode fields into per-cycle datapath enables.
module multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [EXEC_CMD_W-1:0] exec_command,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  wb_enable,
  input  logic                  is_immediate,
  input  logic                  branch_type,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic [EXEC_CMD_W-1:0] alu_cmd,
  output logic                  alu_src_imm,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  rf_write,
  output logic                  wb_sel_mem,
  output logic                  busy,
  output logic                  mem_error,
  output logic [RETIRE_W-1:0]   retired,
  output logic [2:0]            state
);
  state_t cur, nxt;
  dec_fields_t dec;
  logic retire, waiting, expired;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
      dec <= '0;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) dec <= {exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type};
      if (retire) retired <= retired + 1'b1;
    end
  end
  // one timer serves both wait states; a completed handshake always leaves the state, so it re-arms
  assign waiting = (cur == S_FETCH) || (cur == S_MEMORY);
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!waiting || mem_ready),
    .count_en (waiting && !mem_ready),
    .expired  (expired)
  );
  always_comb begin
    nxt = cur;
    retire = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_SRC_SEQ;
    alu_cmd = '0;
    alu_src_imm = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    rf_write = 1'b0;
    wb_sel_mem = 1'b0;
    case (cur)
      S_IDLE: nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt = S_DECODE;
        end else if (expired) nxt = S_ERROR;
      end
      S_DECODE: nxt = (mem_read && mem_write) ? S_ERROR : S_EXECUTE;
      S_EXECUTE: begin
        alu_cmd = dec.cmd;
        alu_src_imm = dec.is_immediate;
        if (dec.branch_type) begin
          pc_write = branch_taken;
          pc_src = PC_SRC_BRANCH;
          retire = 1'b1;
        end else if (dec.mem_read || dec.mem_write) nxt = S_MEMORY;
        else if (dec.wb_enable) nxt = S_WRITEBACK;
        else retire = 1'b1;
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we = dec.mem_write;
        alu_cmd = dec.cmd;
        if (mem_ready) begin
          if (dec.mem_read && dec.wb_enable) nxt = S_WRITEBACK;
          else retire = 1'b1;
        end else if (expired) nxt = S_ERROR;
      end
      S_WRITEBACK: begin
        rf_write = 1'b1;
        wb_sel_mem = dec.mem_read;
        retire = 1'b1;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_ERROR;
    endcase
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end
  assign busy = cur != S_IDLE;
  assign mem_error = cur == S_ERROR;
  assign state = cur;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed plus randomized instruction streams checked cycle by cycle
// against a per-instruction phase list derived from the sequencing rules.
module tb_multicycle_sequencer;
  localparam int TO = 4;
  localparam int RW = 2;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [2:0] exec_command = '0;
  logic mem_read = 0, mem_write = 0, wb_enable = 0, is_immediate = 0, branch_type = 0;
  logic branch_taken = 0, mem_ready = 0;
  logic ir_write, pc_write, pc_src, alu_src_imm, mem_req, mem_we, rf_write, wb_sel_mem, busy, mem_error;
  logic [2:0] alu_cmd, state;
  logic [RW-1:0] retired;
  int checks = 0, failures = 0;
  int cnt = 0;
  logic ni;
  typedef struct {
    logic [2:0] st;
    logic ir, pcw, pcs;
    logic [2:0] cmd;
    logic imm, req, we, rfw, wbm, rdy, dec, tk;
  } exp_t;
  exp_t q[$];

  multicycle_sequencer #(.RETIRE_W(RW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .exec_command(exec_command),
    .mem_read(mem_read), .mem_write(mem_write), .wb_enable(wb_enable),
    .is_immediate(is_immediate), .branch_type(branch_type), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_cmd(alu_cmd), .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we),
    .rf_write(rf_write), .wb_sel_mem(wb_sel_mem), .busy(busy), .mem_error(mem_error),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st);
    exp_t x;
    x = '{default: '0};
    x.st = st;
    return x;
  endfunction

  function automatic logic [17:0] ev(input exp_t x);
    logic [1:0] c;
    c = 2'(cnt);
    return {x.st, x.ir, x.pcw, x.pcs, x.cmd, x.imm, x.req, x.we, x.rfw, x.wbm, x.st != 3'd0, x.st == 3'd7, c};
  endfunction

  function automatic logic [17:0] obs();
    return {state, ir_write, pc_write, pc_src, alu_cmd, alu_src_imm, mem_req, mem_we,
            rf_write, wb_sel_mem, busy, mem_error, retired};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic scramble();
    exec_command = 3'($urandom);
    mem_read = 1'($urandom);
    mem_write = 1'($urandom);
    wb_enable = 1'($urandom);
    is_immediate = 1'($urandom);
    branch_type = 1'($urandom);
    branch_taken = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic idle_step(input logic r);
    @(negedge clk);
    scramble();
    run = r;
    #1 chk("idle", 32'(obs()), 32'(ev(mk(3'd0))));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    cnt = 0;
    #1 chk(tag, 32'(obs()), 32'(ev(mk(3'd0))));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_wait(input logic [2:0] st, input logic [2:0] cmd, input logic we, input int w, output logic err);
    exp_t x;
    x = mk(st);
    x.req = 1'b1;
    x.we = we;
    x.cmd = cmd;
    for (int i = 0; i < ((w >= TO) ? TO : w); i++) q.push_back(x);
    err = (w >= TO);
    if (err) begin
      q.push_back(mk(3'd7));
    end else begin
      x.rdy = 1'b1;
      if (st == 3'd1) begin
        x.ir = 1'b1;
        x.pcw = 1'b1;
      end
      q.push_back(x);
    end
  endtask

  task automatic build(input logic [2:0] cmd, input logic rd, wr, wb, imm, br, tk, input int fw, mw);
    exp_t x;
    logic err;
    q.delete();
    add_wait(3'd1, 3'd0, 1'b0, fw, err);
    if (err) return;
    x = mk(3'd2);
    x.dec = 1'b1;
    q.push_back(x);
    if (rd && wr) begin
      q.push_back(mk(3'd7));
      return;
    end
    x = mk(3'd3);
    x.cmd = cmd;
    x.imm = imm;
    x.tk = tk;
    if (br) begin
      x.pcw = tk;
      x.pcs = 1'b1;
    end
    q.push_back(x);
    if (br) return;
    if (rd || wr) begin
      add_wait(3'd4, cmd, wr, mw, err);
      if (err || !(rd && wb)) return;
    end else if (!wb) return;
    x = mk(3'd5);
    x.rfw = 1'b1;
    x.wbm = rd;
    q.push_back(x);
  endtask

  task automatic run_instr(input logic [2:0] cmd, input logic rd, wr, wb, imm, br, tk,
                           input int fw, mw, input logic run_after, input int abort_at,
                           output logic need_idle);
    exp_t x;
    build(cmd, rd, wr, wb, imm, br, tk, fw, mw);
    need_idle = !run_after;
    for (int i = 0; i < q.size(); i++) begin
      x = q[i];
      @(negedge clk);
      scramble();
      if (x.dec) {exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type} = {cmd, rd, wr, wb, imm, br};
      if (x.st == 3'd3) branch_taken = tk;
      if (x.st == 3'd1 || x.st == 3'd4) mem_ready = x.rdy;
      run = (x.st == 3'd1) ? 1'b1 : run_after;
      #1 chk($sformatf("step st%0d i%0d", x.st, i), 32'(obs()), 32'(ev(x)));
      if (i == abort_at) begin
        rst_n = 1'b0;
        cnt = 0;
        #1 chk("reset_mid_instr", 32'(obs()), 32'(ev(mk(3'd0))));
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        need_idle = 1'b1;
        return;
      end
    end
    if (q[q.size()-1].st == 3'd7) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        scramble();
        run = 1'($urandom);
        #1 chk("error_sticky", 32'(obs()), 32'(ev(mk(3'd7))));
      end
      do_reset("reset_after_error");
      need_idle = 1'b1;
    end else begin
      cnt++;
    end
  endtask

  initial begin
    #2 chk("reset_state", 32'(obs()), 32'(ev(mk(3'd0))));
    @(negedge clk);
    rst_n = 1'b1;
    idle_step(1'b1);
    // ALU with writeback, load with two wait cycles, both branch outcomes, then a NOP that drops run
    run_instr(3'b010, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1, ni);
    run_instr(3'b000, 1, 0, 1, 1, 0, 0, 0, 2, 1, -1, ni);
    run_instr(3'b110, 0, 0, 0, 0, 1, 1, 0, 0, 1, -1, ni);
    run_instr(3'b110, 0, 0, 1, 0, 1, 0, 0, 0, 1, -1, ni);
    run_instr(3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, ni);
    idle_step(1'b0);
    chk("retired_wrap", 32'(retired), 32'd1);
    idle_step(1'b1);
    run_instr(3'b000, 0, 1, 0, 1, 0, 0, 1, 1, 1, -1, ni);
    run_instr(3'b011, 0, 0, 1, 1, 0, 0, TO - 1, 0, 1, -1, ni);
    run_instr(3'b000, 0, 0, 1, 0, 0, 0, TO, 0, 1, -1, ni);
    idle_step(1'b1);
    run_instr(3'b000, 1, 0, 1, 0, 0, 0, 0, TO, 1, -1, ni);
    idle_step(1'b1);
    run_instr(3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 1, -1, ni);
    idle_step(1'b1);
    run_instr(3'b101, 1, 0, 1, 0, 0, 0, 0, 3, 1, 4, ni);
    idle_step(1'b1);
    for (int k = 0; k < 60; k++) begin
      logic rd, wr;
      int fw, mw;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (rd && wr && $urandom_range(0, 7) != 0) wr = 1'b0;
      fw = ($urandom_range(0, 12) == 0) ? TO : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 12) == 0) ? TO : $urandom_range(0, TO - 1);
      run_instr(3'($urandom), rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                fw, mw, 1'($urandom_range(0, 3) != 0), -1, ni);
      if (ni) idle_step(1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
